// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch requester with a small tagged output buffer.
//
// Drives a word address into a memory with a registered read port, tags each returned word with its
// PC, buffers it in a FIFO and hands it to decode over valid/ready. A redirect loads a new PC and
// flushes everything already fetched or in flight.
//
// Ports
//   CLK             in   1   clock, all state on rising edge
//   RST             in   1   synchronous active-high reset
//   imem_addr       out  32  byte address to instruction memory (the fetch PC register)
//   imem_data       in   32  memory read data, valid the cycle after imem_addr was presented
//   redirect_valid  in   1   load redirect_pc this cycle and flush all fetched/in-flight words
//   redirect_pc     in   32  redirect target, bits [1:0] ignored
//   if_valid        out  1   buffer head holds a valid instruction
//   if_pc           out  32  PC of head instruction (0 while empty)
//   if_instr        out  32  head instruction word (0 while empty)
//   id_ready        in   1   decode accepts the head when if_valid & id_ready
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

  // Fetch side
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] resp_pc_q,  resp_pc_d;

  // Output buffer
  fetch_word_t             ent_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q,  count_d;

  logic             pop, push, issue;
  logic [OCC_W-1:0] occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign if_valid  = (count_q != '0);
  assign if_pc     = if_valid ? ent_q[rd_ptr_q].pc    : 32'h0;
  assign if_instr  = if_valid ? ent_q[rd_ptr_q].instr : 32'h0;
  assign imem_addr = fetch_pc_q;

  assign pop  = if_valid & id_ready;
  // A response is only kept when no redirect flushes it this cycle.
  assign push = inflight_q & ~redirect_valid;

  // Credit check: words buffered plus the one possibly in flight, minus the one leaving now, must
  // leave room for another read. pop implies count >= 1, so this never underflows.
  assign occ   = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign issue = ~RST & ~redirect_valid & (occ < OCC_W'(FIFO_DEPTH));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = issue;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (issue) begin
      resp_pc_d  = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect_valid) begin
      // The head popped this cycle is already taken by decode; everything else is dropped.
      fetch_pc_d = redirect_pc & ~32'h3;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      resp_pc_q  <= 32'h0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer storage carries no reset; count_q alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (!RST && push) ent_q[wr_ptr_q] <= '{pc: resp_pc_q, instr: imem_data};
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, redirect_valid, id_ready, if_valid;
  logic [31:0] redirect_pc, imem_addr, imem_data, if_pc, if_instr;

  logic        rst_w, if_valid_w;
  logic [31:0] imem_addr_w, imem_data_w, if_pc_w, if_instr_w;

  int checks = 0, errors = 0, cyc = 0, pops = 0;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .id_ready(id_ready));

  fetch_unit #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(2)) u_w (
    .CLK(CLK), .RST(rst_w), .imem_addr(imem_addr_w), .imem_data(imem_data_w),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .if_valid(if_valid_w), .if_pc(if_pc_w), .if_instr(if_instr_w), .id_ready(1'b1));

  // Memory contents: fixed program at 0/4/8, distinct per-address pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      default: return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  always @(posedge CLK) begin
    cyc         <= cyc + 1;
    imem_data   <= RST   ? 32'h0 : mem_word(imem_addr);
    imem_data_w <= rst_w ? 32'h0 : mem_word(imem_addr_w);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // After a restart at base B, decode must see B, B+4, B+8, ... with mem_word(pc), in order.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] next_pc;

  task automatic push_exp();
    exp_t e;
    e.pc = next_pc; e.instr = mem_word(next_pc);
    exp_q.push_back(e);
    next_pc = next_pc + 32'd4;
  endtask

  task automatic restart(input logic [31:0] base);
    exp_q.delete();
    next_pc = base;
    repeat (4) push_exp();
  endtask

  int          last_ev = -100, stall_run = 0;
  bit          armed = 0, prev_stall = 0;
  logic [31:0] prev_pc, prev_instr, prev_addr;

  always @(negedge CLK) begin
    if (armed) begin
      if (cyc == last_ev + 1 || cyc == last_ev + 2) chk("flush_gap_valid", 32'(if_valid), 32'd0);
      if (cyc == last_ev + 3) begin
        chk("restart_valid", 32'(if_valid), 32'd1);
        chk("restart_pc", if_pc, exp_q[0].pc);
      end
      if (if_valid !== 1'b1) begin
        chk("empty_pc", if_pc, 32'h0);
        chk("empty_instr", if_instr, 32'h0);
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(if_valid), 32'd1);
        chk("stall_pc", if_pc, prev_pc);
        chk("stall_instr", if_instr, prev_instr);
      end
      if (stall_run >= 3 && cyc >= last_ev + 4) chk("stall_addr_frozen", imem_addr, prev_addr);
      if (if_valid && id_ready && !RST) begin
        pops++;
        chk("pop_pc", if_pc, exp_q[0].pc);
        chk("pop_instr", if_instr, exp_q[0].instr);
        void'(exp_q.pop_front());
        push_exp();
      end
    end
    prev_stall = armed && if_valid && !id_ready && !RST && !redirect_valid;
    prev_pc    = if_pc;
    prev_instr = if_instr;
    prev_addr  = imem_addr;
    stall_run  = id_ready ? 0 : stall_run + 1;
    if (RST || redirect_valid) begin
      last_ev = cyc;
      armed   = 1;
      restart(RST ? RST_PC : (redirect_pc & ~32'h3));
    end
  end

  // Wrap-around instance: fixed expected PC sequence, no gaps once started.
  logic [31:0] wq[$] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
  bit w_started = 0;

  always @(negedge CLK) begin
    if (!rst_w && wq.size() > 0) begin
      if (w_started) chk("wrap_gap", 32'(if_valid_w), 32'd1);
      if (if_valid_w) begin
        w_started = 1;
        chk("wrap_pc", if_pc_w, wq[0]);
        chk("wrap_instr", if_instr_w, mem_word(wq[0]));
        void'(wq.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit r, input bit rv, input logic [31:0] tgt, input bit rdy);
    RST = r; redirect_valid = rv; redirect_pc = tgt; id_ready = rdy;
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1; rst_w = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    rst_w = 1'b0;
    // program at 0/4/8 streams out
    repeat (12) drive(0, 0, 32'h0, 1);
    // stall 5 cycles then resume
    repeat (5)  drive(0, 0, 32'h0, 0);
    repeat (10) drive(0, 0, 32'h0, 1);
    // redirect to misaligned 0x43 while buffer is busy
    drive(0, 0, 32'h0, 0);
    drive(0, 1, 32'h43, 0);
    repeat (8) drive(0, 0, 32'h0, 1);
    // redirect with pop, then redirect again next cycle
    drive(0, 1, 32'h200, 1);
    drive(0, 1, 32'h80, 1);
    repeat (8) drive(0, 0, 32'h0, 1);
    // reset pulse with buffered words
    drive(0, 0, 32'h0, 0);
    drive(0, 0, 32'h0, 0);
    drive(1, 0, 32'h0, 1);
    repeat (8) drive(0, 0, 32'h0, 1);
    // redirect across the top of the address space
    drive(0, 1, 32'hFFFF_FFFA, 1);
    repeat (8) drive(0, 0, 32'h0, 1);
    // random traffic
    repeat (3000) begin
      bit r, rv, rdy;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive(r, rv, tgt, rdy);
    end
    repeat (6) drive(0, 0, 32'h0, 1);
    chk("progress_pops", 32'(pops > 1000), 32'd1);
    chk("wrap_seq_done", 32'(wq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
